// File: rtl/move_if.sv
// Drop-request channel between the input stage and the board: valid/ready
// handshake carrying the target column, plus the refusal pulse.
interface move_if;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] move_col;
    logic       move_reject;

    modport master (
        output move_valid,
        output move_col,
        output move_reject,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_col,
        input  move_reject,
        output move_ready
    );
endinterface

// File: rtl/move_input_ctrl.sv
// Connect Four input stage: synchronises/debounces the three player buttons,
// keeps the cursor column and issues one drop request per drop-button press.
module move_input_ctrl #(
    parameter int COLS      = 7,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_drop,
    input  logic [COLS-1:0] col_full,
    input  logic            game_over,
    output logic [2:0]      cursor_col,
    move_if.master          mv
);

    localparam int          BTN_N     = 3;
    localparam int          BTN_LEFT  = 0;
    localparam int          BTN_RIGHT = 1;
    localparam int          BTN_DROP  = 2;
    localparam logic [2:0]  COL_HOME  = 3'(COLS / 2);
    localparam logic [2:0]  COL_LAST  = 3'(COLS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [BTN_N-1:0] btn_raw;
    logic [BTN_N-1:0] btn_level;
    logic [BTN_N-1:0] btn_rise;

    assign btn_raw = {btn_drop, btn_right, btn_left};

    // Per-button 2-flop synchroniser followed by a stability counter.
    // The rise pulse fires in the cycle the level is about to flip, so the
    // FSM reacts on the same edge that the debounced level goes high.
    generate
        for (genvar gi = 0; gi < BTN_N; gi++) begin : g_db
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             flip;

            assign flip = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == CNT_LAST) begin
                            level_reg <= ~level_reg;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign btn_level[gi] = level_reg;
            assign btn_rise[gi]  = flip & ~level_reg;
        end
    endgenerate

    state_t     state_reg,  state_next;
    logic [2:0] cursor_reg, cursor_next;
    logic       valid_reg,  valid_next;
    logic [2:0] col_reg,    col_next;
    logic       reject_reg, reject_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cursor_reg <= COL_HOME;
            valid_reg  <= 1'b0;
            col_reg    <= 3'd0;
            reject_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cursor_reg <= cursor_next;
            valid_reg  <= valid_next;
            col_reg    <= col_next;
            reject_reg <= reject_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cursor_next = cursor_reg;
        valid_next  = valid_reg;
        col_next    = col_reg;
        reject_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // A drop wins over a simultaneous move and uses the old cursor.
                if (btn_rise[BTN_DROP]) begin
                    if (game_over || col_full[cursor_reg]) begin
                        reject_next = 1'b1;
                        state_next  = HOLD;
                    end else begin
                        valid_next = 1'b1;
                        col_next   = cursor_reg;
                        state_next = REQ;
                    end
                end else if (btn_rise[BTN_LEFT] && !btn_rise[BTN_RIGHT]) begin
                    cursor_next = (cursor_reg == 3'd0) ? COL_LAST : cursor_reg - 3'd1;
                end else if (btn_rise[BTN_RIGHT] && !btn_rise[BTN_LEFT]) begin
                    cursor_next = (cursor_reg == COL_LAST) ? 3'd0 : cursor_reg + 3'd1;
                end
            end
            REQ: begin
                // Handshake takes priority over a game-over abort on the same edge.
                if (valid_reg && mv.move_ready) begin
                    valid_next = 1'b0;
                    state_next = HOLD;
                end else if (game_over) begin
                    valid_next = 1'b0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!btn_level[BTN_DROP]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    assign cursor_col     = cursor_reg;
    assign mv.move_valid  = valid_reg;
    assign mv.move_col    = col_reg;
    assign mv.move_reject = reject_reg;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboarded bench for move_input_ctrl: stimulus pushes expected cursor /
// request / reject events, a negedge monitor pops and compares them.
module tb_move_input_ctrl;

    localparam int COLS = 7;
    localparam int DB   = 4;
    localparam int EV_CURSOR = 1;
    localparam int EV_REQ    = 2;
    localparam int EV_REJECT = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            btn_left = 1'b0;
    logic            btn_right = 1'b0;
    logic            btn_drop = 1'b0;
    logic [COLS-1:0] col_full = '0;
    logic            game_over = 1'b0;
    logic [2:0]      cursor_col;

    move_if mif ();

    move_input_ctrl #(.COLS(COLS), .DB_CYCLES(DB), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_drop   (btn_drop),
        .col_full   (col_full),
        .game_over  (game_over),
        .cursor_col (cursor_col),
        .mv         (mif)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  passes = 0;
    ev_t exp_q[$];
    int  model_cur = 3;
    bit  rand_ready = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_event", kind * 100 + val, 0);
        end else begin
            e = exp_q.pop_front();
            chk(e.kind == kind && e.val == val, "event", kind * 100 + val, e.kind * 100 + e.val);
        end
    endtask

    // Reference model: game-level rules in plain arithmetic.
    task automatic mdl_left();
        model_cur = (model_cur + COLS - 1) % COLS;
        push_ev(EV_CURSOR, model_cur);
    endtask

    task automatic mdl_right();
        model_cur = (model_cur + 1) % COLS;
        push_ev(EV_CURSOR, model_cur);
    endtask

    task automatic mdl_drop();
        if (game_over || col_full[model_cur]) push_ev(EV_REJECT, 0);
        else push_ev(EV_REQ, model_cur);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) mif.move_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic press(input int which, input int hold);
        case (which)
            0: btn_left = 1'b1;
            1: btn_right = 1'b1;
            default: btn_drop = 1'b1;
        endcase
        tick(hold);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_drop  = 1'b0;
        tick(12);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mif.move_valid && n < 300) begin
            tick(1);
            n++;
        end
        chk(!mif.move_valid, "request_timeout", n, 0);
    endtask

    // Monitor: decodes DUT output activity into events and checks handshake rules.
    initial begin
        logic [2:0] cur_p = 3'd3;
        logic [2:0] col_p = 3'd0;
        bit v_p = 0, rd_p = 0, go_p = 0, rj_p = 0, rst_p = 1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_p) begin
                chk(cursor_col == 3'd3, "reset_cursor", int'(cursor_col), 3);
                chk(!mif.move_valid, "reset_valid", int'(mif.move_valid), 0);
            end else begin
                if (cursor_col != cur_p) pop_ev(EV_CURSOR, int'(cursor_col));
                if (mif.move_reject) begin
                    if (rj_p) chk(1'b0, "reject_width", 2, 1);
                    else pop_ev(EV_REJECT, 0);
                end
                if (v_p) begin
                    if (rd_p) chk(!mif.move_valid, "valid_after_hs", int'(mif.move_valid), 0);
                    else if (go_p) chk(!mif.move_valid, "abort", int'(mif.move_valid), 0);
                    else begin
                        chk(mif.move_valid, "valid_held", int'(mif.move_valid), 1);
                        chk(mif.move_col == col_p, "col_held", int'(mif.move_col), int'(col_p));
                    end
                end else if (mif.move_valid) begin
                    pop_ev(EV_REQ, int'(mif.move_col));
                end
            end
            cur_p = cursor_col;
            col_p = mif.move_col;
            v_p   = mif.move_valid;
            rd_p  = mif.move_ready;
            go_p  = game_over;
            rj_p  = mif.move_reject;
            rst_p = rst;
        end
    end

    initial begin
        int op;
        mif.move_ready = 1'b0;

        // Reset
        tick(2);
        chk(cursor_col == 3'd3, "rst_cursor", int'(cursor_col), 3);
        chk(!mif.move_valid, "rst_valid", int'(mif.move_valid), 0);
        chk(!mif.move_reject, "rst_reject", int'(mif.move_reject), 0);
        chk(mif.move_col == 3'd0, "rst_col", int'(mif.move_col), 0);
        rst = 1'b0;
        tick(3);

        // Debounce: short glitches are ignored
        for (int g = 1; g <= 3; g++) begin
            btn_right = 1'b1;
            tick(g);
            btn_right = 1'b0;
            tick(10);
            chk(cursor_col == 3'd3, "glitch_ignored", int'(cursor_col), 3);
        end

        // Debounce latency: cursor moves exactly 6 cycles after the press
        mdl_right();
        btn_right = 1'b1;
        tick(5);
        chk(cursor_col == 3'd3, "latency_early", int'(cursor_col), 3);
        tick(1);
        chk(cursor_col == 3'd4, "latency_move", int'(cursor_col), 4);
        tick(4);
        btn_right = 1'b0;
        tick(12);

        // Wrap: 5 more rights reach 2 via 6->0; then back to 0 and left to 6
        for (int i = 0; i < 5; i++) begin
            mdl_right();
            press(1, 8);
        end
        chk(cursor_col == 3'd2, "wrap_right", int'(cursor_col), 2);
        for (int i = 0; i < 2; i++) begin
            mdl_left();
            press(0, 8);
        end
        mdl_left();
        press(0, 8);
        chk(cursor_col == 3'd6, "wrap_left", int'(cursor_col), 6);

        // Handshake at column 2 with delayed ready
        for (int i = 0; i < 3; i++) begin
            mdl_right();
            press(1, 8);
        end
        mdl_drop();
        btn_drop = 1'b1;
        tick(6);
        chk(mif.move_valid, "req_valid", int'(mif.move_valid), 1);
        chk(mif.move_col == 3'd2, "req_col", int'(mif.move_col), 2);
        tick(5);
        chk(mif.move_valid && mif.move_col == 3'd2, "req_stall", int'(mif.move_col), 2);
        mif.move_ready = 1'b1;
        tick(1);
        chk(!mif.move_valid, "req_done", int'(mif.move_valid), 0);
        mif.move_ready = 1'b0;
        tick(20);
        btn_drop = 1'b0;
        tick(12);

        // Reject: full column 3, then game over at column 0
        mdl_right();
        press(1, 8);
        col_full = 7'b0001000;
        mdl_drop();
        press(2, 8);
        col_full = '0;
        for (int i = 0; i < 3; i++) begin
            mdl_left();
            press(0, 8);
        end
        game_over = 1'b1;
        mdl_drop();
        press(2, 8);
        game_over = 1'b0;
        chk(!mif.move_valid, "reject_no_valid", int'(mif.move_valid), 0);

        // Abort by game over while requesting
        mdl_drop();
        btn_drop = 1'b1;
        tick(6);
        chk(mif.move_valid, "abort_pre", int'(mif.move_valid), 1);
        game_over = 1'b1;
        tick(1);
        chk(!mif.move_valid, "abort_valid", int'(mif.move_valid), 0);
        chk(!mif.move_reject, "abort_reject", int'(mif.move_reject), 0);
        game_over = 1'b0;
        btn_drop = 1'b0;
        tick(12);

        // Reset while requesting
        mdl_drop();
        btn_drop = 1'b1;
        tick(6);
        chk(mif.move_valid, "rstreq_pre", int'(mif.move_valid), 1);
        btn_drop = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_cur = 3;
        chk(!mif.move_valid, "rstreq_valid", int'(mif.move_valid), 0);
        chk(cursor_col == 3'd3, "rstreq_cursor", int'(cursor_col), 3);
        tick(12);

        // Randomized moves, drops and glitches with random ready
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin mdl_left();  press(0, $urandom_range(5, 10)); end
                1: begin mdl_right(); press(1, $urandom_range(5, 10)); end
                2: begin
                    col_full = 7'($urandom_range(0, 127));
                    mdl_drop();
                    press(2, $urandom_range(5, 10));
                    wait_idle();
                    col_full = '0;
                    tick(2);
                end
                default: press($urandom_range(0, 2), $urandom_range(1, 3));
            endcase
        end
        rand_ready = 1'b0;
        mif.move_ready = 1'b0;
        tick(10);
        chk(cursor_col == 3'(model_cur), "final_cursor", int'(cursor_col), model_cur);
        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
